wb_spi: RTL



---
 rtl/wb_spi_pkg.sv | 29 ++
 rtl/wb_spi_shift.sv | 109 ++++++++++
 rtl/wb_spi.sv | 127 ++++++++++++
 3 files changed

// File: rtl/wb_spi_pkg.sv
// Shared definitions for the wb_spi Wishbone SPI master.
// Holds the register indices, CTRL/STATUS bit positions and the SPI FSM encoding.
package wb_spi_pkg;

  localparam int unsigned DIV_W  = 8;
  localparam int unsigned BYTE_W = 8;

  // Register indices decoded from adr_i[1:0]
  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_CTRL   = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;

  // CTRL bit positions
  localparam int unsigned CTRL_CS_BIT  = 0;
  localparam int unsigned CTRL_IE_BIT  = 1;
  localparam int unsigned CTRL_DIV_LSB = 8;

  // STATUS bit positions
  localparam int unsigned STATUS_BUSY_BIT = 0;
  localparam int unsigned STATUS_OVR_BIT  = 1;
  localparam int unsigned STATUS_DONE_BIT = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2
  } spi_state_t;

endpackage

// File: rtl/wb_spi_shift.sv
// SPI mode-0 byte engine: shift register, bit/phase counters, sck/mosi generation.
// Ports: clk, rst (sync, active-high), start (load tx_in and begin), div (half-period - 1),
//        tx_in, miso, sck, mosi, busy, done (one-cycle pulse at completion), rx_out.
module spi_shift
  import wb_spi_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DIV_W-1:0]  div,
  input  logic [BYTE_W-1:0] tx_in,
  input  logic              miso,
  output logic              sck,
  output logic              mosi,
  output logic              busy,
  output logic              done,
  output logic [BYTE_W-1:0] rx_out
);

  spi_state_t        state, state_nxt;
  logic [BYTE_W-1:0] shift, shift_nxt;
  logic [2:0]        bit_cnt, bit_cnt_nxt;
  logic [DIV_W-1:0]  phase, phase_nxt;
  logic              sck_nxt, mosi_nxt, done_nxt;
  logic [BYTE_W-1:0] rx_nxt;

  assign busy = (state != ST_IDLE);

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      phase   <= '0;
      sck     <= 1'b0;
      mosi    <= 1'b0;
      done    <= 1'b0;
      rx_out  <= '0;
    end else begin
      state   <= state_nxt;
      shift   <= shift_nxt;
      bit_cnt <= bit_cnt_nxt;
      phase   <= phase_nxt;
      sck     <= sck_nxt;
      mosi    <= mosi_nxt;
      done    <= done_nxt;
      rx_out  <= rx_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start) state_nxt = ST_LOW;
      ST_LOW:  if (phase == '0) state_nxt = ST_HIGH;
      ST_HIGH: if (phase == '0) state_nxt = (bit_cnt != 3'd0) ? ST_LOW : ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath/output next values; MISO sampled on the rising sck, MOSI moved on the falling sck
  always_comb begin
    shift_nxt   = shift;
    bit_cnt_nxt = bit_cnt;
    phase_nxt   = phase;
    sck_nxt     = sck;
    mosi_nxt    = mosi;
    done_nxt    = 1'b0;
    rx_nxt      = rx_out;
    case (state)
      ST_IDLE: begin
        if (start) begin
          shift_nxt   = tx_in;
          bit_cnt_nxt = 3'd7;
          phase_nxt   = div;
          mosi_nxt    = tx_in[BYTE_W-1];
        end
      end
      ST_LOW: begin
        if (phase == '0) begin
          sck_nxt   = 1'b1;
          shift_nxt = {shift[BYTE_W-2:0], miso};
          phase_nxt = div;
        end else begin
          phase_nxt = phase - DIV_W'(1);
        end
      end
      ST_HIGH: begin
        if (phase == '0) begin
          sck_nxt   = 1'b0;
          phase_nxt = div;
          if (bit_cnt != 3'd0) begin
            bit_cnt_nxt = bit_cnt - 3'd1;
            mosi_nxt    = shift[BYTE_W-1];
          end else begin
            rx_nxt   = shift;
            done_nxt = 1'b1;
          end
        end else begin
          phase_nxt = phase - DIV_W'(1);
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/wb_spi.sv
// Wishbone slave SPI master (mode 0, 8-bit, MSB first) with DATA/CTRL/STATUS registers.
// Ports: clk_i, rst_i (sync, active-high), Wishbone cyc_i/stb_i/we_i/adr_i/sel_i/dat_i/ack_o/dat_o,
//        SPI pins spi_sck/spi_mosi/spi_miso/spi_cs (active-low).
// Optional: define WB_SPI_IRQ_EN to add irq_o, CTRL.IE and STATUS.DONE.
module wb_spi
  import wb_spi_pkg::*;
#(
  parameter logic [DIV_W-1:0] DIV_DEFAULT = 8'd59
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [29:0] adr_i,
  input  logic [3:0]  sel_i,
  input  logic [31:0] dat_i,
  output logic        ack_o,
  output logic [31:0] dat_o,
`ifdef WB_SPI_IRQ_EN
  output logic        irq_o,
`endif
  output logic        spi_sck,
  output logic        spi_mosi,
  input  logic        spi_miso,
  output logic        spi_cs
);

  logic [1:0]        reg_idx;
  logic              req, wr, data_wr;
  logic              start, ovr_set, ovr_clr;
  logic              busy, xfer_done;
  logic [BYTE_W-1:0] rx;
  logic [DIV_W-1:0]  div;
  logic              ovr;
  logic [31:0]       rdata;

  // A new request is taken only when ack_o is low, giving one ack per two cycles on a held stb
  assign reg_idx = adr_i[1:0];
  assign req     = cyc_i & stb_i & ~ack_o;
  assign wr      = req & we_i;
  assign data_wr = wr & (reg_idx == REG_DATA) & sel_i[0];
  assign start   = data_wr & ~busy;
  assign ovr_set = data_wr & busy;
  assign ovr_clr = wr & (reg_idx == REG_STATUS) & sel_i[0] & dat_i[STATUS_OVR_BIT];

`ifdef WB_SPI_IRQ_EN
  logic ie, done_flag, done_clr;
  assign done_clr = data_wr | (wr & (reg_idx == REG_STATUS) & sel_i[0] & dat_i[STATUS_DONE_BIT]);

  // Completion flag and interrupt; a completion in the same cycle as a clear wins
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ie        <= 1'b0;
      done_flag <= 1'b0;
      irq_o     <= 1'b0;
    end else begin
      if (wr && (reg_idx == REG_CTRL) && sel_i[0]) ie <= dat_i[CTRL_IE_BIT];
      done_flag <= xfer_done | (done_flag & ~done_clr);
      irq_o     <= done_flag & ie;
    end
  end
`else
  logic unused_done;
  assign unused_done = xfer_done;
`endif

  logic unused_bits;
  assign unused_bits = ^{adr_i[29:2], dat_i[31:16], sel_i[3:2]};

  // Read mux
  always_comb begin
    rdata = '0;
    case (reg_idx)
      REG_DATA: rdata[BYTE_W-1:0] = rx;
      REG_CTRL: begin
        rdata[CTRL_CS_BIT]               = ~spi_cs;
        rdata[CTRL_DIV_LSB +: DIV_W]     = div;
`ifdef WB_SPI_IRQ_EN
        rdata[CTRL_IE_BIT]               = ie;
`endif
      end
      REG_STATUS: begin
        rdata[STATUS_BUSY_BIT] = busy;
        rdata[STATUS_OVR_BIT]  = ovr;
`ifdef WB_SPI_IRQ_EN
        rdata[STATUS_DONE_BIT] = done_flag;
`endif
      end
      default: rdata = '0;
    endcase
  end

  // Bus handshake and control registers; writes commit on the edge that raises ack_o
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_o  <= 1'b0;
      dat_o  <= '0;
      spi_cs <= 1'b1;
      div    <= DIV_DEFAULT;
      ovr    <= 1'b0;
    end else begin
      ack_o <= req;
      dat_o <= (req && !we_i) ? rdata : '0;
      if (wr && (reg_idx == REG_CTRL)) begin
        if (sel_i[0]) spi_cs <= ~dat_i[CTRL_CS_BIT];
        if (sel_i[1]) div    <= dat_i[CTRL_DIV_LSB +: DIV_W];
      end
      ovr <= ovr_set | (ovr & ~ovr_clr);
    end
  end

  spi_shift u_shift (
    .clk    (clk_i),
    .rst    (rst_i),
    .start  (start),
    .div    (div),
    .tx_in  (dat_i[BYTE_W-1:0]),
    .miso   (spi_miso),
    .sck    (spi_sck),
    .mosi   (spi_mosi),
    .busy   (busy),
    .done   (xfer_done),
    .rx_out (rx)
  );

endmodule
